// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake movement controller.
// No logic of its own; no latency.
// No flow control; types only.
package snake_pkg;

    localparam int X_W   = 6;
    localparam int Y_W   = 5;
    localparam int LEN_W = 5;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DEAD
    } state_t;

    // One grid cell occupied by a body segment.
    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } seg_t;

    // The encoding places opposite directions two apart, so flipping bit 1 reverses.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/snake_collide.sv
// Self-collision check of the candidate head cell against the live body.
// Latency: purely combinational.
// No flow control; result is valid whenever inputs are stable.
module snake_collide
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16
) (
    input  seg_t [MAX_LEN-1:0] seg_arr,
    input  logic [LEN_W-1:0]   length,
    input  logic               grow,
    input  seg_t               nxt,
    output logic               hit
);

    // The tail cell vacates on a plain step, so it only counts when growing.
    logic [LEN_W-1:0] lim;
    assign lim = grow ? length : (length - LEN_W'(1));

    // Compare against segments 1..lim-1; segment 0 is the current head and can never match.
    always_comb begin
        hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < lim) && (seg_arr[i] == nxt)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_motion_ctrl.sv
// Snake body/direction state machine advanced by the movement tick.
// Latency: a tick step commits in one cycle; new head visible the next cycle.
// No backpressure: ticks outside RUN are dropped, the read port is combinational.
module snake_motion_ctrl
    import snake_pkg::*;
#(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             update_clk,
    input  logic             start,
    input  logic [1:0]       dir_req,
    input  logic             dir_valid,
    input  logic [X_W-1:0]   food_x,
    input  logic [Y_W-1:0]   food_y,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [X_W-1:0]   rd_x,
    output logic [Y_W-1:0]   rd_y,
    output logic             rd_valid,
    output logic [X_W-1:0]   head_x,
    output logic [Y_W-1:0]   head_y,
    output logic [LEN_W-1:0] length,
    output logic             ate_food,
    output logic             game_over
);

    state_t             state;
    seg_t [MAX_LEN-1:0] seg_q;
    dir_t               cur_dir;
    dir_t               pend_dir;
    logic [LEN_W-1:0]   len_q;

    seg_t nxt;
    logic wall;
    logic grow;
    logic self_hit;

    // Candidate head one cell along pend_dir; the wall test uses the pre-move position.
    always_comb begin
        nxt  = seg_q[0];
        wall = 1'b0;
        case (pend_dir)
            UP: begin
                wall  = (seg_q[0].y == '0);
                nxt.y = seg_q[0].y - Y_W'(1);
            end
            RIGHT: begin
                wall  = (seg_q[0].x == X_W'(GRID_W - 1));
                nxt.x = seg_q[0].x + X_W'(1);
            end
            DOWN: begin
                wall  = (seg_q[0].y == Y_W'(GRID_H - 1));
                nxt.y = seg_q[0].y + Y_W'(1);
            end
            LEFT: begin
                wall  = (seg_q[0].x == '0);
                nxt.x = seg_q[0].x - X_W'(1);
            end
            default: begin
                nxt  = seg_q[0];
                wall = 1'b0;
            end
        endcase
    end

    assign grow = (nxt.x == food_x) && (nxt.y == food_y);

    snake_collide #(
        .MAX_LEN (MAX_LEN)
    ) u_collide (
        .seg_arr (seg_q),
        .length  (len_q),
        .grow    (grow),
        .nxt     (nxt),
        .hit     (self_hit)
    );

    // Game FSM: start/step/death transitions, body shift, growth and direction latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < INIT_LEN) begin
                    seg_q[i].x <= X_W'(GRID_W / 2 - i);
                    seg_q[i].y <= Y_W'(GRID_H / 2);
                end else begin
                    seg_q[i] <= '0;
                end
            end
            cur_dir   <= RIGHT;
            pend_dir  <= RIGHT;
            len_q     <= LEN_W'(INIT_LEN);
            ate_food  <= 1'b0;
            game_over <= 1'b0;
        end else begin
            ate_food <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (update_clk) begin
                        if (wall || self_hit) begin
                            state     <= DEAD;
                            game_over <= 1'b1;
                        end else begin
                            seg_q    <= {seg_q[MAX_LEN-2:0], nxt};
                            cur_dir  <= pend_dir;
                            ate_food <= grow;
                            if (grow && (len_q < LEN_W'(MAX_LEN))) begin
                                len_q <= len_q + LEN_W'(1);
                            end
                        end
                    end
                    // Compared against the direction in effect before this cycle's step.
                    if (dir_valid && (dir_t'(dir_req) != opposite(cur_dir))) begin
                        pend_dir <= dir_t'(dir_req);
                    end
                end
                DEAD: begin
                    game_over <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign head_x   = seg_q[0].x;
    assign head_y   = seg_q[0].y;
    assign length   = len_q;
    assign rd_x     = seg_q[rd_idx].x;
    assign rd_y     = seg_q[rd_idx].y;
    assign rd_valid = ({1'b0, rd_idx} < len_q);

endmodule
